// File: rtl/acc8_unit.sv
`default_nettype none
// ============================================================================
//  Module      : acc8_unit (with helper addsub8)
//  Description : 8-bit accumulator stage wrapped around a combinational
//                add/sub datapath. Accepts one command per valid/ready
//                transfer, executes it in the following cycle and registers
//                the accumulator, the flags and a completed-command count.
//  Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  addsub8 : combinational 8-bit adder/subtractor with flag generation.
//  For subtraction cf reports a borrow (a < b unsigned), not the raw carry.
// ----------------------------------------------------------------------------
module addsub8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    output logic [7:0] sum,
    output logic       cf,
    output logic       ovf,
    output logic       sf,
    output logic       zf
);

    logic [7:0] w_b_eff;
    logic [8:0] w_raw;

    // Subtraction is a + ~b + 1; the carry-in doubles as the +1.
    assign w_b_eff = sub ? ~b : b;
    assign w_raw   = {1'b0, a} + {1'b0, w_b_eff} + {8'b0, sub};
    assign sum     = w_raw[7:0];
    // Carry out of a + ~b + 1 is set when a >= b, so invert it to get borrow.
    assign cf      = sub ? ~w_raw[8] : w_raw[8];
    // Overflow: both effective operands share a sign that the result lacks.
    assign ovf     = (a[7] == w_b_eff[7]) && (w_raw[7] != a[7]);
    assign sf      = w_raw[7];
    assign zf      = (w_raw[7:0] == 8'h00);

endmodule

// ----------------------------------------------------------------------------
//  acc8_unit : two-state (IDLE/EXEC) control and result registers.
// ----------------------------------------------------------------------------
module acc8_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] op,
    input  logic [7:0] operand,
    output logic [7:0] acc,
    output logic       cf,
    output logic       ovf,
    output logic       sf,
    output logic       zf,
    output logic       ovf_sticky,
    output logic       out_valid,
    output logic [7:0] op_count
);

    localparam logic [1:0] C_OP_LOAD  = 2'b00;
    localparam logic [1:0] C_OP_ADD   = 2'b01;
    localparam logic [1:0] C_OP_SUB   = 2'b10;
    localparam logic [1:0] C_OP_CLEAR = 2'b11;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_next;

    logic [1:0] r_op_q;
    logic [7:0] r_opnd_q;

    logic [7:0] r_acc;
    logic       r_cf;
    logic       r_ovf;
    logic       r_sf;
    logic       r_zf;
    logic       r_ovf_sticky;
    logic       r_out_valid;
    logic [7:0] r_op_count;

    logic       w_in_ready;
    logic       w_accept;
    logic       w_commit;

    logic [7:0] w_sum;
    logic       w_cf;
    logic       w_ovf;
    logic       w_sf;
    logic       w_zf;

    // Datapath: accumulator against the latched operand.
    addsub8 u_addsub8 (
        .a   (r_acc),
        .b   (r_opnd_q),
        .sub (r_op_q == C_OP_SUB),
        .sum (w_sum),
        .cf  (w_cf),
        .ovf (w_ovf),
        .sf  (w_sf),
        .zf  (w_zf)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE waits for a transfer, EXEC always lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State-decoded controls; in_ready depends on state only.
    always_comb begin
        w_in_ready = (r_state == S_IDLE);
        w_commit   = (r_state == S_EXEC);
        w_accept   = w_in_ready & in_valid;
    end

    // Command capture on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_q   <= C_OP_LOAD;
            r_opnd_q <= 8'h00;
        end else if (w_accept) begin
            r_op_q   <= op;
            r_opnd_q <= operand;
        end
    end

    // Result commit in EXEC; out_valid is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= 8'h00;
            r_cf         <= 1'b0;
            r_ovf        <= 1'b0;
            r_sf         <= 1'b0;
            r_zf         <= 1'b1;
            r_ovf_sticky <= 1'b0;
            r_out_valid  <= 1'b0;
            r_op_count   <= 8'h00;
        end else begin
            r_out_valid <= w_commit;
            if (w_commit) begin
                r_op_count <= r_op_count + 8'd1;
                case (r_op_q)
                    C_OP_LOAD: begin
                        r_acc <= r_opnd_q;
                        r_cf  <= 1'b0;
                        r_ovf <= 1'b0;
                        r_sf  <= r_opnd_q[7];
                        r_zf  <= (r_opnd_q == 8'h00);
                    end
                    C_OP_ADD, C_OP_SUB: begin
                        r_acc        <= w_sum;
                        r_cf         <= w_cf;
                        r_ovf        <= w_ovf;
                        r_sf         <= w_sf;
                        r_zf         <= w_zf;
                        r_ovf_sticky <= r_ovf_sticky | w_ovf;
                    end
                    default: begin
                        r_acc        <= 8'h00;
                        r_cf         <= 1'b0;
                        r_ovf        <= 1'b0;
                        r_sf         <= 1'b0;
                        r_zf         <= 1'b1;
                        r_ovf_sticky <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign acc        = r_acc;
    assign cf         = r_cf;
    assign ovf        = r_ovf;
    assign sf         = r_sf;
    assign zf         = r_zf;
    assign ovf_sticky = r_ovf_sticky;
    assign out_valid  = r_out_valid;
    assign op_count   = r_op_count;

endmodule
`default_nettype wire
